// File: rtl/matmul_operand_feeder_pkg.sv
// Shared types and sizing helpers for the systolic operand feeder.
package matmul_operand_feeder_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DIM        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Fill (2*DIM-1) plus drain (DIM-1) cycles through the PE pipeline.
  function automatic int run_len(input int dim);
    return 3 * dim - 2;
  endfunction

  function automatic int cnt_width(input int dim);
    return $clog2(run_len(dim));
  endfunction

endpackage

// File: rtl/matmul_skew_lane.sv
// One diagonally skewed operand lane: element k = cnt - LANE_IDX of its vector, else 0.
module matmul_skew_lane
  import matmul_operand_feeder_pkg::*;
#(
  parameter int LANE_IDX   = 0,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIM        = DEF_DIM,
  localparam int CW        = cnt_width(DIM)
) (
  input  logic [DIM*DATA_WIDTH-1:0] vec_i,
  input  logic [CW-1:0]             cnt_i,
  input  logic                      run_i,
  output logic [DATA_WIDTH-1:0]     opnd_o
);

  always_comb begin
    opnd_o = '0;
    for (int k = 0; k < DIM; k++) begin
      if (run_i && (int'(cnt_i) == k + LANE_IDX)) begin
        opnd_o = vec_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/matmul_operand_feeder.sv
// Snapshots A/B on start and streams skewed rows/columns into a DIM x DIM PE array.
// All outputs are registered; lane values are computed from next-state cnt/state.
module matmul_operand_feeder
  import matmul_operand_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DIM        = DEF_DIM
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  input  logic [DIM*DIM*DATA_WIDTH-1:0] a_mat_i,
  input  logic [DIM*DIM*DATA_WIDTH-1:0] b_mat_i,
  input  logic                          ack_i,
  output logic [DIM*DATA_WIDTH-1:0]     a_row_o,
  output logic [DIM*DATA_WIDTH-1:0]     b_col_o,
  output logic                          pe_start_o,
  output logic                          busy_o,
  output logic                          done_o
);

  localparam int RUN_LEN = run_len(DIM);
  localparam int CW      = cnt_width(DIM);
  localparam int VW      = DIM * DATA_WIDTH;
  localparam int MW      = DIM * VW;
  localparam logic [CW-1:0] CNT_LAST = CW'(RUN_LEN - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            latch;
  logic            run_d;
  logic [MW-1:0]   a_snap_q, b_snap_q;
  logic [MW-1:0]   a_src, b_src;
  logic [VW-1:0]   b_cols [DIM];
  logic [VW-1:0]   a_row_d, b_col_d, a_row_q, b_col_q;
  logic            pe_start_q, busy_q, done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          latch   = 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CNT_LAST) state_d = ST_HOLD;
        else                   cnt_d   = cnt_q + 1'b1;
      end
      ST_HOLD: begin
        if (ack_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign run_d = (state_d == ST_RUN);

  // On the latch edge the first lane values must come straight from the inputs.
  assign a_src = latch ? a_mat_i : a_snap_q;
  assign b_src = latch ? b_mat_i : b_snap_q;

  always_comb begin
    b_cols = '{default: '0};
    for (int c = 0; c < DIM; c++) begin
      for (int k = 0; k < DIM; k++) begin
        b_cols[c][k*DATA_WIDTH +: DATA_WIDTH] = b_src[(k*DIM+c)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    matmul_skew_lane #(
      .LANE_IDX  (g),
      .DATA_WIDTH(DATA_WIDTH),
      .DIM       (DIM)
    ) u_a_lane (
      .vec_i (a_src[g*VW +: VW]),
      .cnt_i (cnt_d),
      .run_i (run_d),
      .opnd_o(a_row_d[g*DATA_WIDTH +: DATA_WIDTH])
    );
    matmul_skew_lane #(
      .LANE_IDX  (g),
      .DATA_WIDTH(DATA_WIDTH),
      .DIM       (DIM)
    ) u_b_lane (
      .vec_i (b_cols[g]),
      .cnt_i (cnt_d),
      .run_i (run_d),
      .opnd_o(b_col_d[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      a_snap_q   <= '0;
      b_snap_q   <= '0;
      a_row_q    <= '0;
      b_col_q    <= '0;
      pe_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      if (latch) begin
        a_snap_q <= a_mat_i;
        b_snap_q <= b_mat_i;
      end
      a_row_q    <= a_row_d;
      b_col_q    <= b_col_d;
      pe_start_q <= (state_d != ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_HOLD);
    end
  end

  assign a_row_o    = a_row_q;
  assign b_col_o    = b_col_q;
  assign pe_start_o = pe_start_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Bench for matmul_operand_feeder: DIM=4 with a behavioural PE array, plus DIM=2/3 skew sweeps.
module tb_matmul_operand_feeder;

  localparam int DW = 32;
  localparam int D  = 4;
  localparam int RL = 3*D - 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic ack = 1'b0;
  logic [D*D*DW-1:0] a_mat = '0;
  logic [D*D*DW-1:0] b_mat = '0;
  logic [D*DW-1:0]   a_row, b_col;
  logic pe_start, busy, done;

  logic s_start = 1'b0;
  logic s_ack = 1'b0;
  logic [4*DW-1:0] a2 = '0, b2 = '0;
  logic [9*DW-1:0] a3 = '0, b3 = '0;
  logic [2*DW-1:0] ar2, bc2;
  logic [3*DW-1:0] ar3, bc3;
  logic ps2, bz2, dn2, ps3, bz3, dn3;

  int cmp = 0;
  int bad = 0;
  int A[D][D];
  int B[D][D];
  int SA[3][3];
  int SB[3][3];
  longint res[D][D];
  longint pa[D][D];
  longint pb[D][D];

  always #5 clk = ~clk;

  matmul_operand_feeder #(.DATA_WIDTH(DW), .DIM(D)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .a_mat_i(a_mat), .b_mat_i(b_mat),
    .ack_i(ack), .a_row_o(a_row), .b_col_o(b_col), .pe_start_o(pe_start),
    .busy_o(busy), .done_o(done)
  );

  matmul_operand_feeder #(.DATA_WIDTH(DW), .DIM(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .a_mat_i(a2), .b_mat_i(b2),
    .ack_i(s_ack), .a_row_o(ar2), .b_col_o(bc2), .pe_start_o(ps2),
    .busy_o(bz2), .done_o(dn2)
  );

  matmul_operand_feeder #(.DATA_WIDTH(DW), .DIM(3)) dut3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(s_start), .a_mat_i(a3), .b_mat_i(b3),
    .ack_i(s_ack), .a_row_o(ar3), .b_col_o(bc3), .pe_start_o(ps3),
    .busy_o(bz3), .done_o(dn3)
  );

  // Downstream PE array: operands hop right/down one edge per PE; start low clears.
  function automatic longint a_in(int i, int j);
    if (j == 0) return longint'($signed(a_row[i*DW +: DW]));
    return pa[i][j-1];
  endfunction

  function automatic longint b_in(int i, int j);
    if (i == 0) return longint'($signed(b_col[j*DW +: DW]));
    return pb[i-1][j];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++)
        for (int j = 0; j < D; j++) begin
          res[i][j] <= 0; pa[i][j] <= 0; pb[i][j] <= 0;
        end
    end else begin
      for (int i = 0; i < D; i++)
        for (int j = 0; j < D; j++) begin
          if (pe_start) begin
            res[i][j] <= res[i][j] + a_in(i, j) * b_in(i, j);
            pa[i][j]  <= a_in(i, j);
            pb[i][j]  <= b_in(i, j);
          end else begin
            res[i][j] <= 0; pa[i][j] <= 0; pb[i][j] <= 0;
          end
        end
    end
  end

  function automatic int exp_a(int t, int r);
    int k = t - r;
    if (k >= 0 && k < D) return A[r][k];
    return 0;
  endfunction

  function automatic int exp_b(int t, int c);
    int k = t - c;
    if (k >= 0 && k < D) return B[k][c];
    return 0;
  endfunction

  function automatic int exp_s(int dim, int t, int lane, bit is_a);
    int k = t - lane;
    if (k < 0 || k >= dim) return 0;
    return is_a ? SA[lane][k] : SB[k][lane];
  endfunction

  function automatic longint ref_ab(int i, int j);
    longint s = 0;
    for (int k = 0; k < D; k++) s += longint'(A[i][k]) * longint'(B[k][j]);
    return s;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(200)) - 100;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ab();
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        A[i][j] = rnd(); B[i][j] = rnd();
      end
  endtask

  task automatic load_mats();
    for (int r = 0; r < D; r++)
      for (int k = 0; k < D; k++) begin
        a_mat[(r*D+k)*DW +: DW] = A[r][k];
        b_mat[(r*D+k)*DW +: DW] = B[r][k];
      end
  endtask

  // Start pulse; returns at t=0 of RUN.
  task automatic start_job(bit keep_start);
    load_mats();
    start = 1'b1;
    step();
    if (!keep_start) start = 1'b0;
  endtask

  // Walks RUN from t0, checking lanes each cycle; returns in the first HOLD cycle.
  task automatic stream_check(string tag, int t0, int mutate_t);
    for (int t = t0; t < RL; t++) begin
      if (t == mutate_t) begin
        a_mat = {16{$urandom()}};
        b_mat = ~a_mat;
      end
      for (int l = 0; l < D; l++) begin
        cmp++;
        if ($signed(a_row[l*DW +: DW]) !== exp_a(t, l)) begin
          bad++;
          $display("FAIL %s a_lane%0d t=%0d got %0d expected %0d", tag, l, t,
                   $signed(a_row[l*DW +: DW]), exp_a(t, l));
        end
        cmp++;
        if ($signed(b_col[l*DW +: DW]) !== exp_b(t, l)) begin
          bad++;
          $display("FAIL %s b_lane%0d t=%0d got %0d expected %0d", tag, l, t,
                   $signed(b_col[l*DW +: DW]), exp_b(t, l));
        end
      end
      cmp++;
      if ({pe_start, busy, done} !== 3'b110) begin
        bad++;
        $display("FAIL %s run_flags t=%0d got %b expected 110", tag, t, {pe_start, busy, done});
      end
      step();
    end
    cmp++;
    if ({pe_start, busy, done} !== 3'b111 || a_row !== '0 || b_col !== '0) begin
      bad++;
      $display("FAIL %s hold_entry flags %b lanes_zero %0d expected 111 and 1", tag,
               {pe_start, busy, done}, (a_row == '0) && (b_col == '0));
    end
  endtask

  task automatic check_res(string tag);
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        cmp++;
        if (res[i][j] !== ref_ab(i, j)) begin
          bad++;
          $display("FAIL %s res(%0d,%0d) got %0d expected %0d", tag, i, j, res[i][j], ref_ab(i, j));
        end
      end
  endtask

  task automatic ack_job();
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    cmp++;
    if ({a_row, b_col} !== '0 || {pe_start, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_async outputs nonzero flags %b", {pe_start, busy, done});
    end
    step();
    step();
    cmp++;
    if ({ps2, bz2, dn2, ps3, bz3, dn3} !== 6'b0 || {ar2, bc2, ar3, bc3} !== '0) begin
      bad++;
      $display("FAIL reset_small flags %b expected 0", {ps2, bz2, dn2, ps3, bz3, dn3});
    end
    rst_n = 1'b1;
    step();
    cmp++;
    if ({pe_start, busy, done} !== 3'b000 || a_row !== '0) begin
      bad++;
      $display("FAIL reset_idle flags %b expected 000", {pe_start, busy, done});
    end
  endtask

  task automatic test_identity();
    logic [D*DW-1:0] b_t3;
    b_t3 = {32'd3, 32'd12, 32'd21, 32'd30};
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        A[i][j] = (i == j) ? 1 : 0;
        B[i][j] = 10*i + j;
      end
    start_job(1'b0);
    stream_check("identity", 0, -1);
    check_res("identity");
    ack_job();
    start_job(1'b0);
    for (int t = 0; t < 3; t++) step();
    cmp++;
    if (b_col !== b_t3 || a_row !== '0) begin
      bad++;
      $display("FAIL identity_t3 b_col got %h expected %h, a_row %h expected 0", b_col, b_t3, a_row);
    end
    stream_check("identity_t3on", 3, -1);
    ack_job();
  endtask

  task automatic test_signed();
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        A[i][j] = -3; B[i][j] = 7;
      end
    start_job(1'b0);
    stream_check("signed", 0, -1);
    for (int h = 0; h < 5; h++) begin
      for (int i = 0; i < D; i++)
        for (int j = 0; j < D; j++) begin
          cmp++;
          if (res[i][j] !== -64'sd84) begin
            bad++;
            $display("FAIL signed_hold%0d res(%0d,%0d) got %0d expected -84", h, i, j, res[i][j]);
          end
        end
      cmp++;
      if (done !== 1'b1) begin
        bad++;
        $display("FAIL signed_hold%0d done got %b expected 1", h, done);
      end
      step();
    end
    ack_job();
  endtask

  task automatic test_start_held();
    randomize_ab();
    start_job(1'b1);
    stream_check("start_held", 0, 2);
    check_res("start_held");
    for (int h = 0; h < 3; h++) begin
      step();
      cmp++;
      if (done !== 1'b1 || a_row !== '0 || b_col !== '0) begin
        bad++;
        $display("FAIL start_held_nojob%0d done %b lanes_zero %0d expected 1 1", h, done,
                 (a_row == '0) && (b_col == '0));
      end
    end
    check_res("start_held_stable");
    start = 1'b0;
    ack_job();
    cmp++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_held_idle busy got %b expected 0", busy);
    end
  endtask

  task automatic test_ack_restart();
    randomize_ab();
    start_job(1'b0);
    stream_check("ack_job1", 0, -1);
    check_res("ack_job1");
    ack = 1'b1;
    start = 1'b1;
    step();
    ack = 1'b0;
    start = 1'b0;
    cmp++;
    if ({pe_start, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL ack_idle flags got %b expected 000", {pe_start, busy, done});
    end
    step();
    for (int i = 0; i < D; i++)
      for (int j = 0; j < D; j++) begin
        cmp++;
        if (res[i][j] !== 0) begin
          bad++;
          $display("FAIL ack_clear res(%0d,%0d) got %0d expected 0", i, j, res[i][j]);
        end
      end
    cmp++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL ack_wins busy got %b expected 0", busy);
    end
    randomize_ab();
    start_job(1'b0);
    stream_check("ack_job2", 0, -1);
    check_res("ack_job2");
    ack_job();
  endtask

  task automatic test_reset_midrun();
    randomize_ab();
    start_job(1'b0);
    for (int t = 0; t < 5; t++) step();
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if ({a_row, b_col} !== '0 || {pe_start, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL midrun_reset flags got %b expected 000", {pe_start, busy, done});
    end
    step();
    rst_n = 1'b1;
    step();
    cmp++;
    if ({pe_start, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL midrun_idle flags got %b expected 000", {pe_start, busy, done});
    end
    randomize_ab();
    start_job(1'b0);
    stream_check("after_reset", 0, -1);
    check_res("after_reset");
    ack_job();
  endtask

  task automatic test_skew_sweep();
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) begin
          SA[i][j] = rnd(); SB[i][j] = rnd();
          a3[(i*3+j)*DW +: DW] = SA[i][j];
          b3[(i*3+j)*DW +: DW] = SB[i][j];
          if (i < 2 && j < 2) begin
            a2[(i*2+j)*DW +: DW] = SA[i][j];
            b2[(i*2+j)*DW +: DW] = SB[i][j];
          end
        end
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      for (int t = 0; t < 7; t++) begin
        for (int l = 0; l < 3; l++) begin
          cmp++;
          if ($signed(ar3[l*DW +: DW]) !== exp_s(3, t, l, 1'b1) ||
              $signed(bc3[l*DW +: DW]) !== exp_s(3, t, l, 1'b0)) begin
            bad++;
            $display("FAIL sweep3 lane%0d t=%0d got a=%0d b=%0d expected a=%0d b=%0d", l, t,
                     $signed(ar3[l*DW +: DW]), $signed(bc3[l*DW +: DW]),
                     exp_s(3, t, l, 1'b1), exp_s(3, t, l, 1'b0));
          end
        end
        for (int l = 0; l < 2; l++) begin
          cmp++;
          if ($signed(ar2[l*DW +: DW]) !== ((t < 4) ? exp_s(2, t, l, 1'b1) : 0) ||
              $signed(bc2[l*DW +: DW]) !== ((t < 4) ? exp_s(2, t, l, 1'b0) : 0)) begin
            bad++;
            $display("FAIL sweep2 lane%0d t=%0d got a=%0d b=%0d", l, t,
                     $signed(ar2[l*DW +: DW]), $signed(bc2[l*DW +: DW]));
          end
        end
        cmp++;
        if (dn2 !== (t >= 4) || dn3 !== 1'b0) begin
          bad++;
          $display("FAIL sweep_done t=%0d got dn2=%b dn3=%b expected %b 0", t, dn2, dn3, (t >= 4));
        end
        step();
      end
      cmp++;
      if (dn3 !== 1'b1 || dn2 !== 1'b1 || ar3 !== '0 || bc3 !== '0) begin
        bad++;
        $display("FAIL sweep_hold got dn2=%b dn3=%b expected 1 1", dn2, dn3);
      end
      s_ack = 1'b1;
      step();
      s_ack = 1'b0;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_signed();
    test_start_held();
    test_ack_restart();
    test_reset_midrun();
    test_skew_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
